// File: rtl/pix_serializer.sv
// ---------------------------------------------------------------------------
// pix_serializer
//
// Transmit-side framer. Each accepted pixel (an unsigned Sobel magnitude) is
// saturated to one byte and replicated three times (R, G, B) onto an 8-bit
// AXI-stream heading to the UART transmitter. It is the mirror image of the
// receive path that packs three UART bytes back into one RGB word.
//
// Column/row counters track the position inside the frame so the host can
// resynchronise on line and frame boundaries via the done pulses.
//
// Optional feature (compile-time macro PIX_SER_HEADER_EN):
//   When defined, the first pixel of every frame is preceded by the two
//   sync bytes 8'hA5, 8'h5A. When undefined, the stream carries pixel
//   bytes only.
//
// Parameters
//   WIDTH_P    output byte width; pixels saturate to 2**WIDTH_P-1
//   LINE_W_P   pixels per line
//   FRAME_H_P  lines per frame
//
// Ports
//   clk_i         core clock
//   rst_i         asynchronous, active-high reset
//   data_i        unsigned magnitude pixel (2*WIDTH_P bits)
//   valid_i       data_i valid
//   ready_o       pixel accepted when valid_i & ready_o
//   data_o        byte to UART
//   valid_o       data_o valid
//   ready_i       byte consumed when valid_o & ready_i
//   line_done_o   1-cycle pulse after the last byte of a line is consumed
//   frame_done_o  1-cycle pulse after the last byte of a frame is consumed
// ---------------------------------------------------------------------------
module pix_serializer #(
    parameter int WIDTH_P   = 8,
    parameter int LINE_W_P  = 640,
    parameter int FRAME_H_P = 480
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [2*WIDTH_P-1:0] data_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic [WIDTH_P-1:0]   data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 line_done_o,
    output logic                 frame_done_o
);

    localparam int COL_W = (LINE_W_P  > 1) ? $clog2(LINE_W_P)  : 1;
    localparam int ROW_W = (FRAME_H_P > 1) ? $clog2(FRAME_H_P) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_W_P - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FRAME_H_P - 1);

    // Largest value that still fits in one output byte; anything above it
    // is clipped to all-ones.
    localparam logic [2*WIDTH_P-1:0] SAT_LIMIT = {{WIDTH_P{1'b0}}, {WIDTH_P{1'b1}}};

`ifdef PIX_SER_HEADER_EN
    localparam logic [WIDTH_P-1:0] SYNC_BYTE0 = WIDTH_P'(8'hA5);
    localparam logic [WIDTH_P-1:0] SYNC_BYTE1 = WIDTH_P'(8'h5A);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        B0   = 3'd1,
        B1   = 3'd2,
        B2   = 3'd3,
        H0   = 3'd4,
        H1   = 3'd5
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        B0   = 2'd1,
        B1   = 2'd2,
        B2   = 2'd3
    } state_t;
`endif

    state_t               state_q;
    state_t               state_d;
    state_t               entry_from_idle;
    state_t               entry_from_b2;

    logic [WIDTH_P-1:0]   pix_q;
    logic [WIDTH_P-1:0]   pix_sat;
    logic [COL_W-1:0]     col_q;
    logic [ROW_W-1:0]     row_q;
    logic                 line_done_q;
    logic                 frame_done_q;

    logic                 accept;
    logic                 pix_done;
    logic                 col_wrap;
    logic                 row_wrap;

    // A new pixel can be taken while idle, or in the very cycle the last
    // byte of the current pixel is handed over, which keeps the byte stream
    // free of bubbles. Reset forces ready low even though the state register
    // already reads IDLE.
    assign ready_o  = ~rst_i & ((state_q == IDLE) | ((state_q == B2) & ready_i));
    assign accept   = valid_i & ready_o;

    // The third byte handshake completes a pixel; only that event moves the
    // position counters.
    assign pix_done = (state_q == B2) & ready_i;
    assign col_wrap = (col_q == COL_LAST);
    assign row_wrap = (row_q == ROW_LAST);

    assign pix_sat  = (data_i > SAT_LIMIT) ? {WIDTH_P{1'b1}} : data_i[WIDTH_P-1:0];

    // Choose the first output state for a freshly accepted pixel. With sync
    // headers, a pixel that lands on column 0 / row 0 opens a frame. From B2
    // the counters are about to advance, so the decision looks at the
    // position the counters will hold after this handshake.
`ifdef PIX_SER_HEADER_EN
    assign entry_from_idle = ((col_q == '0) && (row_q == '0)) ? H0 : B0;
    assign entry_from_b2   = (col_wrap && row_wrap) ? H0 : B0;
`else
    assign entry_from_idle = B0;
    assign entry_from_b2   = B0;
`endif

    // State register: reset drops any byte in flight immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Every byte-emitting state only moves on when the
    // UART side takes the byte, so data_o/valid_o hold through back-pressure.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = entry_from_idle;
                end
            end
`ifdef PIX_SER_HEADER_EN
            H0: begin
                if (ready_i) begin
                    state_d = H1;
                end
            end
            H1: begin
                if (ready_i) begin
                    state_d = B0;
                end
            end
`endif
            B0: begin
                if (ready_i) begin
                    state_d = B1;
                end
            end
            B1: begin
                if (ready_i) begin
                    state_d = B2;
                end
            end
            B2: begin
                if (ready_i) begin
                    state_d = accept ? entry_from_b2 : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode: the byte on the bus is purely a function of the state,
    // so it cannot change while a byte is waiting for ready_i.
    always_comb begin
        data_o  = '0;
        valid_o = 1'b0;
        case (state_q)
`ifdef PIX_SER_HEADER_EN
            H0: begin
                data_o  = SYNC_BYTE0;
                valid_o = 1'b1;
            end
            H1: begin
                data_o  = SYNC_BYTE1;
                valid_o = 1'b1;
            end
`endif
            B0, B1, B2: begin
                data_o  = pix_q;
                valid_o = 1'b1;
            end
            default: begin
                data_o  = '0;
                valid_o = 1'b0;
            end
        endcase
    end

    // Pixel holding register, loaded with the saturated value on accept.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pix_q <= '0;
        end else if (accept) begin
            pix_q <= pix_sat;
        end
    end

    // Frame position: column wraps at the end of a line and bumps the row,
    // the row wraps at the end of the frame.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            col_q <= '0;
            row_q <= '0;
        end else if (pix_done) begin
            if (col_wrap) begin
                col_q <= '0;
                row_q <= row_wrap ? '0 : (row_q + ROW_W'(1));
            end else begin
                col_q <= col_q + COL_W'(1);
            end
        end
    end

    // Boundary pulses are registered, so they appear the cycle after the
    // final byte of the line (and frame) has been consumed.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            line_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            line_done_q  <= pix_done & col_wrap;
            frame_done_q <= pix_done & col_wrap & row_wrap;
        end
    end

    assign line_done_o  = line_done_q;
    assign frame_done_o = frame_done_q;

endmodule
